// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // mul: {partial product, remaining multiplier bits}; div: low half dividend -> quotient
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 dvz_q, dvz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // request decode
  logic             op_mul, op_div, op_sgn, op_go;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_mul = (func == F_MULT) || (func == F_MULTU);
  assign op_div = (func == F_DIV)  || (func == F_DIVU);
  assign op_sgn = (func == F_MULT) || (func == F_DIV);
  assign op_go  = start && (state_q == S_IDLE) && (op_mul || op_div);
  assign a_neg  = op_sgn && a[WIDTH-1];
  assign b_neg  = op_sgn && b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // iteration steps
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
  // partial remainder is WIDTH+1 bits; after the trial subtract it always fits WIDTH
  assign div_sh  = {rem_q, acc_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opb_q};
  assign div_sub = div_sh[WIDTH-1:0] - opb_q;

  // sign fix-up
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  assign prod = neg_q_q ? -acc_q : acc_q;
  assign quo  = dvz_q ? {WIDTH{1'b1}} : (neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rmd  = neg_r_q ? -rem_q : rem_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (op_go) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q != S_IDLE);
    done_d = (state_q == S_FIX);
    done   = done_q;
    hi     = hi_q;
    lo     = lo_q;
  end

  // datapath next state
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dvz_d    = dvz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && func == F_MTHI) hi_d = a;
        if (start && func == F_MTLO) lo_d = a;
        if (op_go) begin
          cnt_d    = CW'(WIDTH-1);
          is_div_d = op_div;
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = op_div && a_neg;
          dvz_d    = op_div && (b == '0);
          rem_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
          opb_d    = op_div ? b_mag : a_mag;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          rem_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo;
          hi_d = rmd;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dvz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dvz_q    <= dvz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start an op and follow it to done; cycle 0 is the cycle start is driven
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n, bc, chg;
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; bc = 0; chg = 0;
    func = f; a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (busy) bc++;
      if (hi !== h0 || lo !== l0) chg++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    chk({tag, "_hold"}, 64'(chg), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  6'h18, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op("mult_nn",   6'h18, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F);
    run_op("div_neg",   6'h1a, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",      6'h1b, 32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_z",    6'h1b, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF);
    run_op("div_z",     6'h1a, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",   6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MTLO back to back
    func = 6'h11; a = 32'hCAFE0000; start = 1'b1;
    tick();
    chk("mthi_hi", 64'(hi), 64'h00000000CAFE0000);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_busy", 64'(busy), 64'd0);
    func = 6'h13; a = 32'h0000BEEF;
    tick();
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h000000000000BEEF);
    chk("mtlo_hi", 64'(hi), 64'h00000000CAFE0000);
    chk("mtlo_done", 64'(done), 64'd0);

    // unsupported func leaves everything alone
    func = 6'h20; a = 32'h11111111; b = 32'h2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_hilo", {hi, lo}, 64'hCAFE00000000BEEF);

    // second start while busy is dropped
    func = 6'h18; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    func = 6'h19; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) begin
        dn++;
        chk("ign_hi", 64'(hi), 64'd0);
        chk("ign_lo", 64'(lo), 64'd15);
      end
      tick();
    end
    chk("ign_done_count", 64'(dn), 64'd1);

    // reset mid-operation aborts with no done pulse
    func = 6'h18; a = 32'd123; b = 32'd456; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    func = 6'h19; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dn++;
      tick();
    end
    chk("abort_quiet", 64'(dn), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
